// File: rtl/dma_copier_mc.sv
// Single-channel DMA engine: COPY (mem-to-mem) or FILL (constant pattern), with fixed-address sides.
// Latency: 2 cycles/beat COPY, 1 cycle/beat FILL at zero wait; finished one cycle after last write grant.
// Backpressure: each request holds address/data/strobe steady until mem_ready; abort never cuts one.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   start, mode, src_fixed, dst_fixed, src_addr, dst_addr, fill_data, copy_size
//                             launch request and configuration, latched in IDLE on start
//   abort                     finish the in-flight access, then stop
//   busy, finished, aborted, remaining
//                             status towards the control block
//   mem_ren, mem_wen, mem_addr, mem_wdata, mem_rdata, mem_ready
//                             shared memory request port
module dma_copier_mc #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              mode,
  input  logic              src_fixed,
  input  logic              dst_fixed,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [LEN_W-1:0]  copy_size,
  input  logic              abort,
  output logic              busy,
  output logic              finished,
  output logic              aborted,
  output logic [LEN_W-1:0]  remaining,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic MODE_FILL = 1'b1;

  state_t            state_q,     state_d;
  logic              mode_q,      mode_d;
  logic              src_fixed_q, src_fixed_d;
  logic              dst_fixed_q, dst_fixed_d;
  logic [ADDR_W-1:0] src_q,       src_d;
  logic [ADDR_W-1:0] dst_q,       dst_d;
  logic [DATA_W-1:0] fill_q,      fill_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              abort_q,     abort_d;
  logic              busy_q,      busy_d;
  logic              finished_q,  finished_d;
  logic              aborted_q,   aborted_d;
  logic              mem_ren_q,   mem_ren_d;
  logic              mem_wen_q,   mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Abort seen in the current cycle counts as latched, so an abort raised on
  // the grant cycle of a read still suppresses that read's write.
  logic abort_any;
  assign abort_any = abort_q | abort;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_fixed_d = src_fixed_q;
    dst_fixed_d = dst_fixed_q;
    src_d       = src_q;
    dst_d       = dst_q;
    fill_d      = fill_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    abort_d     = abort_q;
    aborted_d   = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          src_fixed_d = src_fixed;
          dst_fixed_d = dst_fixed;
          src_d       = src_addr;
          dst_d       = dst_addr;
          fill_d      = fill_data;
          remaining_d = copy_size;
          abort_d     = 1'b0;
          aborted_d   = 1'b0;
          if (copy_size == '0) begin
            state_d = S_DONE;
          end else if (mode == MODE_FILL) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        abort_d = abort_any;
        if (mem_ready) begin
          data_d = mem_rdata;
          if (!src_fixed_q) begin
            src_d = src_q + ADDR_W'(1);
          end
          // An aborted read still completes but its write is dropped.
          state_d = abort_any ? S_DONE : S_WRITE;
        end
      end

      S_WRITE: begin
        abort_d = abort_any;
        if (mem_ready) begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          if (!dst_fixed_q) begin
            dst_d = dst_q + ADDR_W'(1);
          end
          if (remaining_q == LEN_W'(1) || abort_any) begin
            state_d = S_DONE;
          end else if (mode_q == MODE_FILL) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // aborted is captured on entry to DONE and then held until the next start.
    if (state_d == S_DONE) begin
      aborted_d = abort_d;
    end

    // All outputs are registered from the next-state view so they line up
    // with the state they describe.
    busy_d      = (state_d != S_IDLE);
    finished_d  = (state_d == S_DONE);
    mem_ren_d   = (state_d == S_READ);
    mem_wen_d   = (state_d == S_WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == S_READ) begin
      mem_addr_d = src_d;
    end else if (state_d == S_WRITE) begin
      mem_addr_d  = dst_d;
      mem_wdata_d = (mode_d == MODE_FILL) ? fill_d : data_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      src_fixed_q <= 1'b0;
      dst_fixed_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      fill_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      aborted_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_fixed_q <= src_fixed_d;
      dst_fixed_q <= dst_fixed_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      aborted_q   <= aborted_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign finished  = finished_q;
  assign aborted   = aborted_q;
  assign remaining = remaining_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dma_copier_mc.sv
// Bench for dma_copier_mc: table of transfers against a behavioural memory, plus reset-mid-transfer.
// Latency expectations are in cycles from the cycle start is driven to the cycle finished is high.
// Memory side inserts optional 0-3 cycle stalls per request and checks request stability during them.
module tb_dma_copier_mc;

  logic       CLK, nRST;
  logic       start, mode, src_fixed, dst_fixed, abort;
  logic [7:0] src_addr, dst_addr, fill_data, copy_size;
  logic       busy, finished, aborted;
  logic [7:0] remaining;
  logic       mem_ren, mem_wen, mem_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  dma_copier_mc #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .mode(mode),
    .src_fixed(src_fixed), .dst_fixed(dst_fixed),
    .src_addr(src_addr), .dst_addr(dst_addr), .fill_data(fill_data),
    .copy_size(copy_size), .abort(abort), .busy(busy), .finished(finished),
    .aborted(aborted), .remaining(remaining), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic            mode, src_fixed, dst_fixed, stall, fifo, glitch;
    logic [7:0]      src, dst, fill, size;
    int              abort_rd;   // abort during this read number (1-based), 0 = never
    logic [7:0]      pre_base;
    int              pre_cnt;
    logic [4:0][7:0] pre_data;   // memory preload, or FIFO contents when fifo=1
    int              exp_rd, exp_wr;
    logic [4:0][7:0] exp_raddr, exp_waddr, exp_wdata;
    logic            exp_aborted;
    logic [7:0]      exp_rem;
    int              exp_fin;    // 0 = timing not checked (random stalls)
  } vec_t;

  vec_t tv[9];

  int n_chk = 0;
  int n_fail = 0;

  // Memory model state
  logic [7:0]      mem[256];
  logic [4:0][7:0] pre_cur;
  logic            fifo_mode = 1'b0;
  logic            stall_en = 1'b0;
  logic            mon_en = 1'b0;
  int              stall_cnt = 0;
  int              abort_rd = 0;
  int              rd_cnt = 0;
  int              wr_cnt = 0;
  logic [7:0]      exp_rem = 8'd0;
  logic [7:0]      rd_log[8];
  logic [7:0]      wa_log[8];
  logic [7:0]      wd_log[8];
  logic            prev_pend = 1'b0;
  logic [17:0]     prev_req = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0][7:0] pk(input logic [7:0] b0, b1, b2, b3, b4);
    logic [4:0][7:0] r;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3; r[4] = b4;
    return r;
  endfunction

  task automatic set_cfg(input int i, input logic m, sf, df, st, ff, gl,
                         input logic [7:0] s, d, f, n, input int ab);
    tv[i].mode = m; tv[i].src_fixed = sf; tv[i].dst_fixed = df;
    tv[i].stall = st; tv[i].fifo = ff; tv[i].glitch = gl;
    tv[i].src = s; tv[i].dst = d; tv[i].fill = f; tv[i].size = n;
    tv[i].abort_rd = ab;
  endtask

  task automatic set_exp(input int i, input logic [7:0] pb, input int pc,
                         input logic [4:0][7:0] pd, input int nr, input logic [4:0][7:0] ra,
                         input int nw, input logic [4:0][7:0] wa, input logic [4:0][7:0] wd,
                         input logic ea, input logic [7:0] er, input int ef);
    tv[i].pre_base = pb; tv[i].pre_cnt = pc; tv[i].pre_data = pd;
    tv[i].exp_rd = nr; tv[i].exp_raddr = ra;
    tv[i].exp_wr = nw; tv[i].exp_waddr = wa; tv[i].exp_wdata = wd;
    tv[i].exp_aborted = ea; tv[i].exp_rem = er; tv[i].exp_fin = ef;
  endtask

  // Memory responder / monitor: everything happens on the falling edge, where
  // DUT outputs are settled; a grant decided here takes effect at the next rise.
  initial begin
    logic req;
    mem_ready = 1'b1;
    mem_rdata = 8'h00;
    abort     = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (busy) chk("remaining_track", 32'(remaining), 32'(exp_rem));
        chk("ren_wen_exclusive", 32'(mem_ren & mem_wen), 32'd0);
        if (prev_pend) chk("req_stable_in_stall", 32'({mem_ren, mem_wen, mem_addr, mem_wdata}), 32'(prev_req));
      end
      abort = (abort_rd != 0) && mem_ren && (rd_cnt == abort_rd - 1);
      req = mem_ren | mem_wen;
      if (stall_en && req && stall_cnt > 0) begin
        mem_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_ready = 1'b1;
        if (req) stall_cnt = stall_en ? int'($urandom_range(0, 3)) : 0;
      end
      mem_rdata = fifo_mode ? ((rd_cnt < 5) ? pre_cur[rd_cnt] : 8'h00) : mem[mem_addr];
      prev_pend = req && !mem_ready;
      prev_req  = {mem_ren, mem_wen, mem_addr, mem_wdata};
      if (mem_ready && nRST) begin
        if (mem_ren && rd_cnt < 8) begin
          rd_log[rd_cnt] = mem_addr;
          rd_cnt++;
        end
        if (mem_wen && wr_cnt < 8) begin
          wa_log[wr_cnt] = mem_addr;
          wd_log[wr_cnt] = mem_wdata;
          mem[mem_addr]  = mem_wdata;
          wr_cnt++;
          exp_rem = exp_rem - 8'd1;
        end
      end
    end
  end

  // Called just after a falling edge with the DUT idle; start is driven at once.
  task automatic run_vec(input int idx);
    vec_t v;
    int   cyc;
    logic seen;
    string p;
    v = tv[idx];
    p = $sformatf("v%0d", idx);
    if (!v.fifo) for (int i = 0; i < v.pre_cnt; i++) mem[8'(v.pre_base + 8'(i))] = v.pre_data[i];
    pre_cur   = v.pre_data;
    fifo_mode = v.fifo;
    stall_en  = v.stall;
    stall_cnt = v.stall ? int'($urandom_range(0, 3)) : 0;
    abort_rd  = v.abort_rd;
    rd_cnt    = 0;
    wr_cnt    = 0;
    exp_rem   = v.size;
    mon_en    = 1'b1;
    mode = v.mode; src_fixed = v.src_fixed; dst_fixed = v.dst_fixed;
    src_addr = v.src; dst_addr = v.dst; fill_data = v.fill; copy_size = v.size;
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (v.glitch && cyc == 2) begin
        // start while busy with a different configuration must be ignored
        start = 1'b1; mode = ~v.mode; src_addr = 8'h00; dst_addr = 8'hEE;
        copy_size = 8'd7; fill_data = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (finished) seen = 1'b1;
    end
    chk({p, " finished_seen"}, 32'(seen), 32'd1);
    if (v.exp_fin != 0) chk({p, " finish_cycle"}, 32'(cyc), 32'(v.exp_fin));
    chk({p, " aborted"}, 32'(aborted), 32'(v.exp_aborted));
    chk({p, " remaining_final"}, 32'(remaining), 32'(v.exp_rem));
    @(negedge CLK);
    chk({p, " finished_one_cycle"}, 32'(finished), 32'd0);
    chk({p, " busy_after_done"}, 32'(busy), 32'd0);
    mon_en = 1'b0;
    chk({p, " read_count"}, 32'(rd_cnt), 32'(v.exp_rd));
    chk({p, " write_count"}, 32'(wr_cnt), 32'(v.exp_wr));
    for (int i = 0; i < v.exp_rd && i < rd_cnt; i++)
      chk($sformatf("%s read_addr[%0d]", p, i), 32'(rd_log[i]), 32'(v.exp_raddr[i]));
    for (int i = 0; i < v.exp_wr && i < wr_cnt; i++) begin
      chk($sformatf("%s write_addr[%0d]", p, i), 32'(wa_log[i]), 32'(v.exp_waddr[i]));
      chk($sformatf("%s write_data[%0d]", p, i), 32'(wd_log[i]), 32'(v.exp_wdata[i]));
    end
  endtask

  initial begin
    logic [4:0][7:0] z;
    z = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    nRST = 1'b0; start = 1'b0; mode = 1'b0; src_fixed = 1'b0; dst_fixed = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; fill_data = 8'h00; copy_size = 8'h00;

    //       idx mode sf df stall fifo glitch src    dst    fill   size   abort_rd
    set_cfg(0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h80, 8'h00, 8'd4, 0);
    set_cfg(1, 1, 0, 0, 1, 0, 0, 8'h00, 8'hFE, 8'h5A, 8'd3, 0);
    set_cfg(2, 0, 1, 0, 0, 1, 0, 8'h40, 8'h20, 8'h00, 8'd3, 0);
    set_cfg(3, 0, 0, 0, 0, 0, 0, 8'h30, 8'h90, 8'h00, 8'd5, 2);
    set_cfg(4, 0, 0, 0, 0, 0, 0, 8'h10, 8'h80, 8'h00, 8'd0, 0);
    set_cfg(5, 1, 0, 1, 0, 0, 0, 8'h00, 8'h70, 8'hC3, 8'd2, 0);
    set_cfg(6, 0, 0, 0, 0, 0, 0, 8'hFF, 8'h05, 8'h00, 8'd2, 0);
    set_cfg(7, 0, 0, 0, 0, 0, 1, 8'h50, 8'h60, 8'h00, 8'd2, 0);
    set_cfg(8, 0, 0, 0, 0, 0, 0, 8'h12, 8'hA0, 8'h00, 8'd1, 0);

    set_exp(0, 8'h10, 4, pk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00),
            4, pk(8'h10, 8'h11, 8'h12, 8'h13, 8'h00),
            4, pk(8'h80, 8'h81, 8'h82, 8'h83, 8'h00), pk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00),
            1'b0, 8'd0, 9);
    set_exp(1, 8'h00, 0, z, 0, z,
            3, pk(8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00), pk(8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00),
            1'b0, 8'd0, 0);
    set_exp(2, 8'h00, 0, pk(8'h11, 8'h22, 8'h33, 8'h00, 8'h00),
            3, pk(8'h40, 8'h40, 8'h40, 8'h00, 8'h00),
            3, pk(8'h20, 8'h21, 8'h22, 8'h00, 8'h00), pk(8'h11, 8'h22, 8'h33, 8'h00, 8'h00),
            1'b0, 8'd0, 7);
    set_exp(3, 8'h30, 5, pk(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4),
            2, pk(8'h30, 8'h31, 8'h00, 8'h00, 8'h00),
            1, pk(8'h90, 8'h00, 8'h00, 8'h00, 8'h00), pk(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00),
            1'b1, 8'd4, 4);
    set_exp(4, 8'h00, 0, z, 0, z, 0, z, z, 1'b0, 8'd0, 1);
    set_exp(5, 8'h00, 0, z, 0, z,
            2, pk(8'h70, 8'h70, 8'h00, 8'h00, 8'h00), pk(8'hC3, 8'hC3, 8'h00, 8'h00, 8'h00),
            1'b0, 8'd0, 3);
    set_exp(6, 8'hFF, 2, pk(8'hE1, 8'hE2, 8'h00, 8'h00, 8'h00),
            2, pk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00),
            2, pk(8'h05, 8'h06, 8'h00, 8'h00, 8'h00), pk(8'hE1, 8'hE2, 8'h00, 8'h00, 8'h00),
            1'b0, 8'd0, 5);
    set_exp(7, 8'h50, 2, pk(8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00),
            2, pk(8'h50, 8'h51, 8'h00, 8'h00, 8'h00),
            2, pk(8'h60, 8'h61, 8'h00, 8'h00, 8'h00), pk(8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00),
            1'b0, 8'd0, 5);
    set_exp(8, 8'h12, 1, pk(8'hA2, 8'h00, 8'h00, 8'h00, 8'h00),
            1, pk(8'h12, 8'h00, 8'h00, 8'h00, 8'h00),
            1, pk(8'hA0, 8'h00, 8'h00, 8'h00, 8'h00), pk(8'hA2, 8'h00, 8'h00, 8'h00, 8'h00),
            1'b0, 8'd0, 3);

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst finished", 32'(finished), 32'd0);
    chk("rst aborted", 32'(aborted), 32'd0);
    chk("rst remaining", 32'(remaining), 32'd0);
    chk("rst mem_ren", 32'(mem_ren), 32'd0);
    chk("rst mem_wen", 32'(mem_wen), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset dropped while a write is pending: everything clears at once.
    fifo_mode = 1'b0; stall_en = 1'b0; abort_rd = 0; mon_en = 1'b0;
    mode = 1'b0; src_fixed = 1'b0; dst_fixed = 1'b0;
    src_addr = 8'h10; dst_addr = 8'hB0; copy_size = 8'd3; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 0; k < 20 && !mem_wen; k++) @(negedge CLK);
    chk("rstmid reached_write", 32'(mem_wen), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("rstmid mem_wen", 32'(mem_wen), 32'd0);
    chk("rstmid mem_ren", 32'(mem_ren), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid remaining", 32'(remaining), 32'd0);
    chk("rstmid finished", 32'(finished), 32'd0);
    @(negedge CLK);
    chk("rstmid finished_held", 32'(finished), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    run_vec(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
